bitty_pipe_ctrl: RTL and testbench
==================================

Name: bitty_pipe_ctrl

Overview:
Parametrised pipeline controller for the bittyCore, succeeding the fixed 3-bit stall controller.
- Generalised to NUM_STAGES stages, with separate per-stage stall and flush vectors.
- Handles multi-cycle stall sources from ID, EX and MEM, and prioritises trap redirects over branch redirects.
- Registers the PC redirect and runs a stall watchdog.
- Sits beside the core datapath: it drives pc_reg and every pipeline register (if_id, id_ex, ex_mem, mem_wb).

Parameters:
NUM_STAGES, 5, pipeline depth; stage 0 = IF, stage NUM_STAGES-1 = WB
ADDR_W, 32, instruction address width
EX_STAGE, 2, stage index that resolves branches and raises stallreq_ex
MEM_STAGE, 3, stage index that raises traps and stallreq_mem
WDOG_W, 8, watchdog counter width
STALL_TIMEOUT, 255, consecutive stall cycles before timeout_o sets; must be ≤ 2^WDOG_W-1

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stallreq_id  input  1  load-use hazard request from ID (stage 1)
stallreq_ex  input  1  multi-cycle EX operation busy (level)
stallreq_mem  input  1  data bus not ready (level)
branch_flag_i  input  1  taken branch/jump resolved in EX
branch_addr_i  input  ADDR_W  branch target
trap_flag_i  input  1  exception/interrupt raised in MEM
trap_addr_i  input  ADDR_W  trap vector
stall_o  output  NUM_STAGES  bit i=1: stage-i input register holds its value
flush_o  output  NUM_STAGES  bit i=1: stage-i input register loads a bubble
redirect_o  output  1  PC load strobe, registered
redirect_addr_o  output  ADDR_W  PC load target, registered
timeout_o  output  1  sticky stall watchdog flag

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, watchdog counter 0, any pending redirect dropped. Reset mid-stall or mid-redirect takes effect the same way.
- Stall composition, combinational:
  - k = highest stage index with an active request (ID=1, EX=EX_STAGE, MEM=MEM_STAGE).
  - stall_o[0..k]=1.
  - flush_o[k+1]=1 if k+1<NUM_STAGES.
  - No request: stall_o=0.
- Redirect acceptance, evaluated in cycle N:
  - trap_flag_i is always accepted. Cycle N flush: flush_o[1..MEM_STAGE]=1, which overrides stall_o on the same bits.
  - branch_flag_i is accepted only if trap_flag_i=0, stallreq_ex=0 and stallreq_mem=0. Otherwise it is ignored; EX re-presents it once unstalled. Cycle N flush: flush_o[1..EX_STAGE]=1.
  - Trap has priority over branch in the same cycle.
- Redirect register:
  - In cycle N+1, redirect_o=1 for exactly one cycle, with redirect_addr_o = the accepted address.
  - Also in N+1, flush_o[1]=1 to kill the wrong-path fetch from cycle N.
  - redirect_o overrides stall_o[0]: pc_reg loads the address even while stalled.
  - redirect_addr_o holds its last value when redirect_o=0.
- Back-to-back redirects in N and N+1: the second wins in N+2. The N+1 pulse is still emitted.
- Watchdog:
  - The counter increments on each cycle with any stall_o bit set and saturates at 2^WDOG_W-1.
  - It clears on any cycle with stall_o=0.
  - When the counter reaches STALL_TIMEOUT, timeout_o sets on the next edge and stays set until reset.
- No combinational path from the redirect inputs to redirect_o.

Optional Feature:
Macro BITTY_PIPE_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cyc_o (32) and perf_flush_evt_o (32), reset to 0.
  - perf_stall_cyc_o increments each cycle stall_o[0]=1.
  - perf_flush_evt_o increments once per accepted redirect.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- stallreq_id=1 for 1 cycle, defaults -> stall_o=5'b00011, flush_o=5'b00100, redirect_o=0.
- stallreq_ex=1 with stallreq_id=1 -> stall_o=5'b00111, flush_o=5'b01000. Then stallreq_mem=1 as well -> stall_o=5'b01111, flush_o=5'b10000.
- branch_flag_i=1, branch_addr_i=0x0000_0100 in cycle N, no stalls -> cycle N: flush_o=5'b00110. Cycle N+1: redirect_o=1, redirect_addr_o=0x100, flush_o=5'b00010. Cycle N+2: redirect_o=0.
- trap_flag_i=1 (0x0000_0080) and branch_flag_i=1 (0x0000_0200) same cycle -> flush_o=5'b01110, next cycle redirect_addr_o=0x80. Branch with stallreq_mem=1 -> no redirect_o pulse.
- stallreq_mem held 300 cycles, STALL_TIMEOUT=255 -> timeout_o rises after the 255th stall cycle and stays 1 after stallreq_mem drops. rst=1 for 1 cycle -> timeout_o=0, all outputs 0.
- Reset asserted in cycle N+1 after an accepted branch -> redirect_o=0 in N+2; no pulse appears after reset releases.

Source files
------------

// File: rtl/bitty_pipe_ctrl.sv
// Pipeline stall/flush controller for bittyCore: per-stage stall and flush vectors, registered
// trap/branch PC redirect and a sticky stall watchdog. Define BITTY_PIPE_PERF_EN for perf counters.
module bitty_pipe_ctrl #(
  parameter int unsigned NUM_STAGES    = 5,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned EX_STAGE      = 2,
  parameter int unsigned MEM_STAGE     = 3,
  parameter int unsigned WDOG_W        = 8,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallreq_id,
  input  logic                  stallreq_ex,
  input  logic                  stallreq_mem,
  input  logic                  branch_flag_i,
  input  logic [ADDR_W-1:0]     branch_addr_i,
  input  logic                  trap_flag_i,
  input  logic [ADDR_W-1:0]     trap_addr_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  redirect_o,
  output logic [ADDR_W-1:0]     redirect_addr_o,
  output logic                  timeout_o
`ifdef BITTY_PIPE_PERF_EN
  ,
  output logic [31:0]           perf_stall_cyc_o,
  output logic [31:0]           perf_flush_evt_o
`endif
);

  localparam logic [WDOG_W-1:0] WdogMax    = '1;
  localparam logic [WDOG_W-1:0] WdogOne    = WDOG_W'(1);
  localparam logic [WDOG_W-1:0] TimeoutVal = WDOG_W'(STALL_TIMEOUT);

  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  trap_acc;
  logic                  branch_acc;

  logic                  redirect_q, redirect_d;
  logic [ADDR_W-1:0]     redirect_addr_q, redirect_addr_d;
  logic [WDOG_W-1:0]     wdog_cnt_q, wdog_cnt_d;
  logic                  timeout_q, timeout_d;
`ifdef BITTY_PIPE_PERF_EN
  logic [31:0]           perf_stall_q, perf_stall_d;
  logic [31:0]           perf_flush_q, perf_flush_d;
`endif

  always_comb begin
    stall_raw  = '0;
    flush      = '0;
    trap_acc   = trap_flag_i;
    // A stalled EX/MEM cannot commit a branch; EX re-presents it once unstalled.
    branch_acc = branch_flag_i & ~trap_flag_i & ~stallreq_ex & ~stallreq_mem;

    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      stall_raw[i] = (stallreq_id  && (i <= 1))        ||
                     (stallreq_ex  && (i <= EX_STAGE)) ||
                     (stallreq_mem && (i <= MEM_STAGE));
    end

    // The stall mask is contiguous from stage 0, so its upper edge marks the bubble slot.
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      flush[i] = (stall_raw[i-1] && !stall_raw[i])   ||
                 (trap_acc   && (i <= MEM_STAGE))    ||
                 (branch_acc && (i <= EX_STAGE))     ||
                 (redirect_q && (i == 1));
    end

    stall = stall_raw & ~flush;
    if (redirect_q) begin
      stall[0] = 1'b0;
    end

    redirect_d      = trap_acc | branch_acc;
    redirect_addr_d = trap_acc   ? trap_addr_i   :
                      branch_acc ? branch_addr_i : redirect_addr_q;

    if (|stall) begin
      wdog_cnt_d = (wdog_cnt_q == WdogMax) ? wdog_cnt_q : wdog_cnt_q + WdogOne;
    end else begin
      wdog_cnt_d = '0;
    end
    timeout_d = timeout_q | (wdog_cnt_q >= TimeoutVal);

`ifdef BITTY_PIPE_PERF_EN
    perf_stall_d = perf_stall_q + {31'b0, stall[0]};
    perf_flush_d = perf_flush_q + {31'b0, redirect_d};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      wdog_cnt_q      <= '0;
      timeout_q       <= 1'b0;
`ifdef BITTY_PIPE_PERF_EN
      perf_stall_q    <= '0;
      perf_flush_q    <= '0;
`endif
    end else begin
      redirect_q      <= redirect_d;
      redirect_addr_q <= redirect_addr_d;
      wdog_cnt_q      <= wdog_cnt_d;
      timeout_q       <= timeout_d;
`ifdef BITTY_PIPE_PERF_EN
      perf_stall_q    <= perf_stall_d;
      perf_flush_q    <= perf_flush_d;
`endif
    end
  end

  assign stall_o         = stall;
  assign flush_o         = flush;
  assign redirect_o      = redirect_q;
  assign redirect_addr_o = redirect_addr_q;
  assign timeout_o       = timeout_q;
`ifdef BITTY_PIPE_PERF_EN
  assign perf_stall_cyc_o = perf_stall_q;
  assign perf_flush_evt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_bitty_pipe_ctrl.sv
// Self-checking bench for bitty_pipe_ctrl: directed test-plan steps plus random traffic,
// compared each cycle against a behavioural model of the stall/flush/redirect rules.
module tb_bitty_pipe_ctrl;

  localparam int NS   = 5;
  localparam int AW   = 32;
  localparam int EXS  = 2;
  localparam int MEMS = 3;
  localparam int WW   = 8;
  localparam int TO   = 255;
  localparam int CMAX = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallreq_id, stallreq_ex, stallreq_mem;
  logic          branch_flag_i, trap_flag_i;
  logic [AW-1:0] branch_addr_i, trap_addr_i;
  logic [NS-1:0] stall_o, flush_o;
  logic          redirect_o, timeout_o;
  logic [AW-1:0] redirect_addr_o;
`ifdef BITTY_PIPE_PERF_EN
  logic [31:0]   perf_stall_cyc_o, perf_flush_evt_o;
  logic [31:0]   m_perf_stall, m_perf_flush;
`endif

  bitty_pipe_ctrl #(
    .NUM_STAGES(NS), .ADDR_W(AW), .EX_STAGE(EXS), .MEM_STAGE(MEMS),
    .WDOG_W(WW), .STALL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
    .trap_flag_i(trap_flag_i), .trap_addr_i(trap_addr_i),
    .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o),
    .timeout_o(timeout_o)
`ifdef BITTY_PIPE_PERF_EN
    , .perf_stall_cyc_o(perf_stall_cyc_o), .perf_flush_evt_o(perf_flush_evt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model state: the pending redirect, its address, watchdog count and sticky flag.
  bit            m_redir;
  logic [AW-1:0] m_addr;
  int            m_cnt;
  bit            m_to;
  bit            m_acc;
  logic [AW-1:0] m_acc_addr;
  logic [NS-1:0] exp_stall, exp_flush;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_comb();
    int k;
    k = -1;
    if (stallreq_id) k = 1;
    if (stallreq_ex && EXS > k) k = EXS;
    if (stallreq_mem && MEMS > k) k = MEMS;
    exp_stall = (k >= 0) ? NS'((1 << (k + 1)) - 1) : '0;
    exp_flush = (k >= 0 && k + 1 < NS) ? NS'(1 << (k + 1)) : '0;
    m_acc      = 1'b0;
    m_acc_addr = '0;
    if (trap_flag_i) begin
      m_acc      = 1'b1;
      m_acc_addr = trap_addr_i;
      exp_flush  = exp_flush | NS'((1 << (MEMS + 1)) - 2);
    end else if (branch_flag_i && !stallreq_ex && !stallreq_mem) begin
      m_acc      = 1'b1;
      m_acc_addr = branch_addr_i;
      exp_flush  = exp_flush | NS'((1 << (EXS + 1)) - 2);
    end
    if (m_redir) begin
      exp_flush    = exp_flush | NS'(2);
      exp_stall[0] = 1'b0;
    end
    exp_stall = exp_stall & ~exp_flush;
  endfunction

  // Check one cycle against the model mid-cycle, then advance across the clock edge.
  task automatic step();
    #3;
    model_comb();
    if (!rst) begin
      check("stall_o", 64'(stall_o), 64'(exp_stall));
      check("flush_o", 64'(flush_o), 64'(exp_flush));
      check("redirect_o", 64'(redirect_o), 64'(m_redir));
      check("redirect_addr_o", 64'(redirect_addr_o), 64'(m_addr));
      check("timeout_o", 64'(timeout_o), 64'(m_to));
`ifdef BITTY_PIPE_PERF_EN
      check("perf_stall_cyc_o", 64'(perf_stall_cyc_o), 64'(m_perf_stall));
      check("perf_flush_evt_o", 64'(perf_flush_evt_o), 64'(m_perf_flush));
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_redir = 1'b0;
      m_addr  = '0;
      m_cnt   = 0;
      m_to    = 1'b0;
`ifdef BITTY_PIPE_PERF_EN
      m_perf_stall = '0;
      m_perf_flush = '0;
`endif
    end else begin
      if (m_cnt >= TO) m_to = 1'b1;
      m_cnt   = (exp_stall != '0) ? ((m_cnt < CMAX) ? m_cnt + 1 : CMAX) : 0;
      m_redir = m_acc;
      if (m_acc) m_addr = m_acc_addr;
`ifdef BITTY_PIPE_PERF_EN
      m_perf_stall = m_perf_stall + 32'(exp_stall[0]);
      m_perf_flush = m_perf_flush + 32'(m_acc);
`endif
    end
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_id   = 1'b0;
    stallreq_ex   = 1'b0;
    stallreq_mem  = 1'b0;
    branch_flag_i = 1'b0;
    trap_flag_i   = 1'b0;
    branch_addr_i = '0;
    trap_addr_i   = '0;
  endtask

  initial begin
    idle_inputs();
    m_redir = 1'b0;
    m_addr  = '0;
    m_cnt   = 0;
    m_to    = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    #2;
    check("rst_stall", 64'(stall_o), 64'h0);
    check("rst_flush", 64'(flush_o), 64'h0);
    check("rst_redirect", 64'(redirect_o), 64'h0);
    check("rst_addr", 64'(redirect_addr_o), 64'h0);
    check("rst_timeout", 64'(timeout_o), 64'h0);
    step();

    // Load-use stall from ID.
    stallreq_id = 1'b1;
    #2;
    check("id_stall", 64'(stall_o), 64'h03);
    check("id_flush", 64'(flush_o), 64'h04);
    check("id_redirect", 64'(redirect_o), 64'h0);
    step();
    stallreq_ex = 1'b1;
    #2;
    check("ex_stall", 64'(stall_o), 64'h07);
    check("ex_flush", 64'(flush_o), 64'h08);
    step();
    stallreq_mem = 1'b1;
    #2;
    check("mem_stall", 64'(stall_o), 64'h0f);
    check("mem_flush", 64'(flush_o), 64'h10);
    step();
    idle_inputs();
    step();

    // Taken branch, no stalls.
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h0000_0100;
    #2;
    check("br_n_flush", 64'(flush_o), 64'h06);
    step();
    idle_inputs();
    #2;
    check("br_n1_redirect", 64'(redirect_o), 64'h1);
    check("br_n1_addr", 64'(redirect_addr_o), 64'h100);
    check("br_n1_flush", 64'(flush_o), 64'h02);
    step();
    #2;
    check("br_n2_redirect", 64'(redirect_o), 64'h0);
    step();

    // Trap beats branch in the same cycle.
    trap_flag_i   = 1'b1;
    trap_addr_i   = 32'h0000_0080;
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h0000_0200;
    #2;
    check("trap_flush", 64'(flush_o), 64'h0e);
    step();
    idle_inputs();
    #2;
    check("trap_redirect", 64'(redirect_o), 64'h1);
    check("trap_addr", 64'(redirect_addr_o), 64'h80);
    step();

    // Branch under a MEM stall is ignored.
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h0000_0300;
    stallreq_mem  = 1'b1;
    step();
    idle_inputs();
    #2;
    check("br_memstall_redirect", 64'(redirect_o), 64'h0);
    check("br_memstall_addr", 64'(redirect_addr_o), 64'h80);
    step();

    // Back-to-back redirects: second one wins a cycle later.
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h0000_0400;
    step();
    branch_addr_i = 32'h0000_0500;
    #2;
    check("b2b_first_addr", 64'(redirect_addr_o), 64'h400);
    step();
    idle_inputs();
    #2;
    check("b2b_second_redirect", 64'(redirect_o), 64'h1);
    check("b2b_second_addr", 64'(redirect_addr_o), 64'h500);
    step();

    // Watchdog: 300 cycles of MEM stall.
    stallreq_mem = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 200) check("wdog_early", 64'(timeout_o), 64'h0);
      step();
    end
    idle_inputs();
    #2;
    check("wdog_set", 64'(timeout_o), 64'h1);
    step();
    #2;
    check("wdog_sticky", 64'(timeout_o), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    check("wdog_rst_timeout", 64'(timeout_o), 64'h0);
    check("wdog_rst_redirect", 64'(redirect_o), 64'h0);
    check("wdog_rst_stall", 64'(stall_o), 64'h0);
    step();

    // Reset while a redirect is pending.
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h0000_0600;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    check("rstmid_redirect", 64'(redirect_o), 64'h0);
    check("rstmid_addr", 64'(redirect_addr_o), 64'h0);
    step();
    #2;
    check("rstmid_after", 64'(redirect_o), 64'h0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(99) == 0);
      stallreq_id   = ($urandom_range(99) < 15);
      stallreq_ex   = ($urandom_range(99) < 12);
      stallreq_mem  = ($urandom_range(99) < 10);
      branch_flag_i = ($urandom_range(99) < 25);
      trap_flag_i   = ($urandom_range(99) < 8);
      branch_addr_i = $urandom;
      trap_addr_i   = $urandom;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
